// File: rtl/tinymoa_serial_mul.sv
// Multi-cycle shift-add multiplier for the TinyMOA execute stage.
// Retires STEP multiplier bits per clock and supports MUL, MULH, MULHSU and MULHU.
module tinymoa_serial_mul #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_in,
    input  logic             abort_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out
);
    localparam int unsigned N  = WIDTH / STEP;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

    state_t           state, state_next;
    logic [1:0]       op, op_next;
    logic [DW-1:0]    mcand, mcand_next;
    logic [WIDTH-1:0] mplier, mplier_next;
    logic             neg, neg_next;
    logic [DW-1:0]    acc, acc_next;
    logic [CW-1:0]    count, count_next;
    logic             done, done_next;
    logic [WIDTH-1:0] result, result_next;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [DW-1:0]    digit, partial, signed_acc;

    always_comb begin
        // MUL takes the unsigned path: its low word is sign-agnostic.
        a_neg = ((op_in == 2'b01) || (op_in == 2'b10)) && a_in[WIDTH-1];
        b_neg = (op_in == 2'b01) && b_in[WIDTH-1];
        a_mag = a_neg ? -a_in : a_in;
        b_mag = b_neg ? -b_in : b_in;

        digit      = {{(DW-STEP){1'b0}}, mplier[STEP-1:0]};
        partial    = mcand * digit;
        signed_acc = neg ? -acc : acc;

        state_next  = state;
        op_next     = op;
        mcand_next  = mcand;
        mplier_next = mplier;
        neg_next    = neg;
        acc_next    = acc;
        count_next  = count;
        done_next   = 1'b0;
        result_next = result;

        case (state)
            StIdle: begin
                if (start_in) begin
                    op_next     = op_in;
                    mcand_next  = {{WIDTH{1'b0}}, a_mag};
                    mplier_next = b_mag;
                    neg_next    = a_neg ^ b_neg;
                    acc_next    = '0;
                    count_next  = '0;
                    state_next  = StRun;
                end
            end
            StRun: begin
                if (abort_in) begin
                    state_next = StIdle;
                end else begin
                    acc_next    = acc + partial;
                    mcand_next  = mcand << STEP;
                    mplier_next = mplier >> STEP;
                    count_next  = count + 1'b1;
                    if (count == CW'(N - 1)) begin
                        state_next = StFix;
                    end
                end
            end
            StFix: begin
                if (abort_in) begin
                    state_next = StIdle;
                end else begin
                    result_next = (op == 2'b00) ? signed_acc[WIDTH-1:0]
                                                : signed_acc[DW-1:WIDTH];
                    done_next   = 1'b1;
                    state_next  = StIdle;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= StIdle;
            op     <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            count  <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_next;
            op     <= op_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            neg    <= neg_next;
            acc    <= acc_next;
            count  <= count_next;
            done   <= done_next;
            result <= result_next;
        end
    end

    assign busy_out   = (state != StIdle);
    assign done_out   = done;
    assign result_out = result;

endmodule

// File: tb/tb_tinymoa_serial_mul.sv
// Self-checking bench for tinymoa_serial_mul: three instances (32/4, 8/2, 16/1)
// checked against a plain-arithmetic reference product.
module tb_tinymoa_serial_mul;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        start0, start1, start2;
    logic        abort0, abort1, abort2;
    logic [1:0]  op0, op1, op2;
    logic [31:0] a32, b32, res32;
    logic [7:0]  a8, b8, res8;
    logic [15:0] a16, b16, res16;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;

    int checks = 0;
    int errors = 0;

    tinymoa_serial_mul #(.WIDTH(32), .STEP(4)) dut (
        .clk(clk), .rstn(rstn), .start_in(start0), .abort_in(abort0), .op_in(op0),
        .a_in(a32), .b_in(b32), .busy_out(busy0), .done_out(done0), .result_out(res32)
    );
    tinymoa_serial_mul #(.WIDTH(8), .STEP(2)) dut8 (
        .clk(clk), .rstn(rstn), .start_in(start1), .abort_in(abort1), .op_in(op1),
        .a_in(a8), .b_in(b8), .busy_out(busy1), .done_out(done1), .result_out(res8)
    );
    tinymoa_serial_mul #(.WIDTH(16), .STEP(1)) dut16 (
        .clk(clk), .rstn(rstn), .start_in(start2), .abort_in(abort2), .op_in(op2),
        .a_in(a16), .b_in(b16), .busy_out(busy2), .done_out(done2), .result_out(res16)
    );

    // Reference: extend operands per op signedness, form the full product, pick a word.
    function automatic logic [31:0] model(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [127:0] sa, sb, p, m;
        m  = (128'sd1 <<< w) - 128'sd1;
        sa = $signed({96'd0, a}) & m;
        sb = $signed({96'd0, b}) & m;
        if ((op == 2'b01 || op == 2'b10) && a[w-1]) sa = sa - (128'sd1 <<< w);
        if (op == 2'b01 && b[w-1]) sb = sb - (128'sd1 <<< w);
        p = sa * sb;
        if (op == 2'b00) return 32'(p & m);
        return 32'((p >>> w) & m);
    endfunction

    function automatic int width_of(input int idx);
        return (idx == 0) ? 32 : (idx == 1) ? 8 : 16;
    endfunction

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 9 : (idx == 1) ? 5 : 17;
    endfunction

    function automatic logic get_done(input int idx);
        return (idx == 0) ? done0 : (idx == 1) ? done1 : done2;
    endfunction

    function automatic logic get_busy(input int idx);
        return (idx == 0) ? busy0 : (idx == 1) ? busy1 : busy2;
    endfunction

    function automatic logic [31:0] get_res(input int idx);
        return (idx == 0) ? res32 : (idx == 1) ? {24'd0, res8} : {16'd0, res16};
    endfunction

    task automatic drive(input int idx, input logic s, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        case (idx)
            0: begin start0 = s; op0 = op; a32 = a; b32 = b; end
            1: begin start1 = s; op1 = op; a8 = a[7:0]; b8 = b[7:0]; end
            default: begin start2 = s; op2 = op; a16 = a[15:0]; b16 = b[15:0]; end
        endcase
    endtask

    // Starts one op, then checks latency, result, busy profile and done pulse width.
    task automatic run_op(input int idx, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string name);
        int lat;
        bit busy_bad;
        lat = 0;
        busy_bad = 0;
        drive(idx, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(idx, 1'b0, op, a, b);
        for (int e = 1; e <= 60 && lat == 0; e++) begin
            @(posedge clk); #1;
            if (get_done(idx)) lat = e;
            else if (!get_busy(idx)) busy_bad = 1;
        end
        checks++;
        if (lat != lat_of(idx)) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, lat_of(idx));
        end
        checks++;
        if (get_res(idx) !== exp) begin
            errors++;
            $display("FAIL %s result: got %h, expected %h", name, get_res(idx), exp);
        end
        checks++;
        if (busy_bad || get_busy(idx) !== 1'b0) begin
            errors++;
            $display("FAIL %s busy profile: dropped early=%0d, busy at done=%b, expected 0/0",
                     name, busy_bad, get_busy(idx));
        end
        @(posedge clk); #1;
        checks++;
        if (get_done(idx) !== 1'b0) begin
            errors++;
            $display("FAIL %s done width: done=%b one edge later, expected 0", name,
                     get_done(idx));
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start0 = 0; start1 = 0; start2 = 0;
        abort0 = 0; abort1 = 0; abort2 = 0;
        op0 = 0; op1 = 0; op2 = 0;
        a32 = 0; b32 = 0; a8 = 0; b8 = 0; a16 = 0; b16 = 0;
        #2;
        checks++;
        if ({busy0, done0, busy1, done1, busy2, done2} !== 6'b0) begin
            errors++;
            $display("FAIL reset flags: got %b, expected 000000",
                     {busy0, done0, busy1, done1, busy2, done2});
        end
        checks++;
        if (res32 !== 32'd0 || res8 !== 8'd0 || res16 !== 16'd0) begin
            errors++;
            $display("FAIL reset result: got %h/%h/%h, expected 0", res32, res8, res16);
        end
        @(posedge clk); #2;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFF9, "mul_neg1x7");
        run_op(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_minxmin");
        run_op(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_neg1");
        run_op(0, 2'b01, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "mulh_3xm2");
    endtask

    task automatic test_small_widths();
        run_op(1, 2'b11, 32'hFF, 32'hFF, 32'hFE, "w8_mulhu");
        run_op(1, 2'b00, 32'h80, 32'h80, 32'h00, "w8_mul");
        run_op(2, 2'b01, 32'h8000, 32'h0001, 32'hFFFF, "w16_mulh");
    endtask

    task automatic test_random();
        int idx, w, pick;
        logic [1:0] op;
        logic [31:0] a, b;
        logic [63:0] mk;
        for (int i = 0; i < 30; i++) begin
            idx = int'($urandom_range(0, 2));
            w = width_of(idx);
            mk = (64'd1 << w) - 64'd1;
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            pick = int'($urandom_range(0, 5));
            if (pick == 0) a = 32'h8000_0000 >> (32 - w);
            if (pick == 1) b = 32'hFFFF_FFFF;
            if (pick == 2) b = 32'd0;
            a = a & mk[31:0];
            b = b & mk[31:0];
            run_op(idx, op, a, b, model(w, op, a, b), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        int done_edges[$];
        logic [31:0] done_res[$];
        drive(0, 1'b1, 2'b00, 32'd6, 32'd7);
        @(posedge clk); #1;
        for (int e = 1; e <= 30; e++) begin
            if (e == 3 || e == 5) drive(0, 1'b1, 2'b00, 32'd9, 32'd9);
            else if (e == 9 || e == 10) drive(0, 1'b1, 2'b00, 32'd3, 32'd4);
            else drive(0, 1'b0, 2'b00, 32'd0, 32'd0);
            @(posedge clk); #1;
            if (done0) begin
                done_edges.push_back(e);
                done_res.push_back(res32);
            end
        end
        checks++;
        if (done_edges.size() != 2) begin
            errors++;
            $display("FAIL b2b pulse count: got %0d, expected 2", done_edges.size());
        end
        if (done_edges.size() >= 1) begin
            checks++;
            if (done_edges[0] != 9 || done_res[0] !== 32'd42) begin
                errors++;
                $display("FAIL b2b first: got edge %0d value %0d, expected edge 9 value 42",
                         done_edges[0], done_res[0]);
            end
        end
        if (done_edges.size() >= 2) begin
            checks++;
            if (done_edges[1] != 19 || done_res[1] !== 32'd12) begin
                errors++;
                $display("FAIL b2b second: got edge %0d value %0d, expected edge 19 value 12",
                         done_edges[1], done_res[1]);
            end
        end
    endtask

    // Starts MULHU max, asserts abort so it is sampled at edge at_edge, checks aftermath.
    task automatic abort_at(input int at_edge, input string name);
        bit saw_done;
        saw_done = 0;
        drive(0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(0, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int e = 1; e < at_edge; e++) begin
            @(posedge clk); #1;
        end
        abort0 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL %s after abort: busy=%b done=%b, expected 0/0", name, busy0, done0);
        end
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            if (done0) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL %s spurious done: got 1, expected none", name);
        end
        checks++;
        if (res32 !== 32'd42) begin
            errors++;
            $display("FAIL %s result kept: got %h, expected %h", name, res32, 32'd42);
        end
    endtask

    task automatic test_abort();
        run_op(0, 2'b00, 32'd6, 32'd7, 32'd42, "abort_setup");
        abort_at(4, "abort_run");
        abort_at(9, "abort_fix");
    endtask

    task automatic test_reset_mid();
        run_op(0, 2'b00, 32'd6, 32'd7, 32'd42, "rst_setup");
        drive(0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(0, 1'b0, 2'b00, 32'd0, 32'd0);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || res32 !== 32'd0) begin
            errors++;
            $display("FAIL async reset: busy=%b done=%b result=%h, expected 0/0/0",
                     busy0, done0, res32);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL post-reset idle: busy=%b done=%b, expected 0/0", busy0, done0);
        end
        run_op(0, 2'b00, 32'd3, 32'd5, 32'd15, "after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_small_widths();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
